icache_refill_ctrl: RTL
=======================

Name: icache_refill_ctrl

Overview:
- Sequences instruction-cache line refills for the fetch stage.
- On a fetch miss it issues one line-aligned request to the memory port and collects DATA_W-wide response beats into a full line.
- It then writes the line into the cache arrays and pulses a done signal so fetch can replay.
- A pipeline flush during a refill does not abort the memory transaction: the line is still written, but the replay notification is suppressed.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, memory response beat width.
- LINE_W, 256, cache line width; must be a multiple of DATA_W. BEATS = LINE_W/DATA_W (default 8).
- CNT_W, 16, width of the completed-refill counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- miss_i  in  1  fetch miss strobe (hit_cache=0 on a valid fetch)
- miss_addr_i  in  ADDR_W  PC that missed
- flush_i  in  1  pipeline flush (must_flush)
- mem_req_valid_o  out  1  line request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_W  line-aligned request address
- mem_rsp_valid_i  in  1  response beat valid
- mem_rsp_data_i  in  DATA_W  response beat data
- line_we_o  out  1  cache line write enable
- line_addr_o  out  ADDR_W  line-aligned write address
- line_data_o  out  LINE_W  assembled line
- refill_done_o  out  1  one-cycle replay pulse to fetch
- busy_o  out  1  controller not in IDLE
- refill_cnt_o  out  CNT_W  completed refills, wraps modulo 2^CNT_W

Behaviour:
- Reset: synchronous, active-low. At the first clk edge with rst_n=0 the following are cleared: state to IDLE, beat counter, kill flag, line buffer, address register, refill_cnt_o. All outputs read 0 during and directly after reset. Reset mid-refill abandons the transaction; beats arriving after reset are ignored in IDLE.
- Address: captured_addr = miss_addr_i with the low log2(LINE_W/8) bits zeroed. mem_req_addr_o and line_addr_o both drive captured_addr.
- IDLE:
  - miss_i=1 and flush_i=0: capture the address, go to REQ. mem_req_valid_o=1 on the next cycle.
  - miss_i=1 and flush_i=1 in the same cycle: flush wins; stay in IDLE.
  - Response beats are ignored.
- REQ:
  - mem_req_valid_o=1. Address is held stable until mem_req_valid_o & mem_req_ready_i. The request is never retracted.
  - On handshake go to FILL with beat counter = 0.
  - Response beats in REQ are ignored.
- FILL:
  - Each cycle with mem_rsp_valid_i=1 writes beat k into line bits [k*DATA_W +: DATA_W], lowest beat first, then increments k.
  - The beat with k = BEATS-1 moves to WRITE on the next cycle.
  - Gaps between beats (mem_rsp_valid_i=0) are allowed with no timeout.
- WRITE: one cycle.
  - line_we_o=1, with line_data_o/line_addr_o valid.
  - refill_done_o=1 only if the kill flag is clear.
  - refill_cnt_o increments regardless of kill.
  - Next state is IDLE; clear the kill flag.
- Kill flag: set by flush_i=1 in any of REQ, FILL or WRITE.
  - A flush in the WRITE cycle itself also suppresses refill_done_o in that cycle (combinational gate on flush_i).
- Back-to-back misses: miss_i while busy is ignored; fetch stalls on busy_o. A new miss is accepted in the first IDLE cycle after WRITE.
- busy_o = (state != IDLE).
- Latency: with ready=1 and back-to-back beats, a miss in cycle N gives:
  - request handshake at N+1
  - beats N+2 .. N+1+BEATS
  - line_we/refill_done at N+2+BEATS (N+10 for default parameters).
- Width rules: beat counter is log2(BEATS) bits and must not wrap before WRITE. refill_cnt_o wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package icache_pkg:
  - refill_state_e enum {IDLE, REQ, FILL, WRITE}
  - localparams BEATS and OFFSET_W
  - function line_align(addr)
- Sub-module icache_line_assembler: beat counter plus line buffer. It has a beat-valid input and clear input, and produces line and last-beat outputs. The controller FSM stays in icache_refill_ctrl.

Test Plan:
- Basic refill:
  - Stimulus: miss_i at PC 0x0000_1234, ready=1, beats 0x11111111..0x88888888.
  - Response: mem_req_addr_o=0x0000_1220; line_we_o and refill_done_o at N+10; line_data_o[31:0]=0x11111111 and [255:224]=0x88888888; refill_cnt_o=1.
- Backpressure and gaps:
  - Stimulus: ready low for 5 cycles, then beats with one idle cycle between each.
  - Response: address held stable and valid held high throughout; exactly one handshake; line written after the 8th beat only.
- Flush during FILL:
  - Stimulus: flush_i after beat 3.
  - Response: all 8 beats absorbed; line_we_o=1; refill_done_o stays 0; refill_cnt_o still increments.
- Same-cycle miss and flush in IDLE:
  - Response: no request issued; busy_o stays 0.
- Reset mid-FILL:
  - Stimulus: rst_n=0 after beat 4, then beats continue.
  - Response: IDLE, all outputs 0, remaining beats ignored. A subsequent miss at 0x40 refills cleanly with address 0x40.
- Miss while busy, then counter wrap:
  - Stimulus: second miss_i during FILL; refill_cnt_o preloaded via 2^16-1 refills (or CNT_W=2 run).
  - Response: second miss is ignored; counter wraps to 0.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared refill types, default geometry and address helpers
package icache_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_CNT_W = 16;
  localparam int BEATS = DEF_LINE_W / DEF_DATA_W;
  localparam int OFFSET_W = $clog2(DEF_LINE_W / 8);
  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} refill_state_e;
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned offset_w);
    return addr & ~((64'd1 << offset_w) - 64'd1);
  endfunction
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: fetch, memory and cache-array signals of the refill controller
interface icache_refill_ctrl_if import icache_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic miss_i;
  logic [ADDR_W-1:0] miss_addr_i;
  logic flush_i;
  logic mem_req_valid_o;
  logic mem_req_ready_i;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic mem_rsp_valid_i;
  logic [DATA_W-1:0] mem_rsp_data_i;
  logic line_we_o;
  logic [ADDR_W-1:0] line_addr_o;
  logic [LINE_W-1:0] line_data_o;
  logic refill_done_o;
  logic busy_o;
  logic [CNT_W-1:0] refill_cnt_o;
  modport master (
    input miss_i, miss_addr_i, flush_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    output mem_req_valid_o, mem_req_addr_o, line_we_o, line_addr_o, line_data_o,
    output refill_done_o, busy_o, refill_cnt_o
  );
  modport slave (
    output miss_i, miss_addr_i, flush_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    input mem_req_valid_o, mem_req_addr_o, line_we_o, line_addr_o, line_data_o,
    input refill_done_o, busy_o, refill_cnt_o
  );
endinterface

// File: rtl/icache_refill_ctrl_assembler.sv
// icache_line_assembler: beat counter and line buffer, lowest beat first
module icache_line_assembler import icache_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic beat_valid,
  input  logic [DATA_W-1:0] beat_data,
  output logic [LINE_W-1:0] line,
  output logic last
);
  localparam int NB = LINE_W / DATA_W;
  localparam int KW = NB > 1 ? $clog2(NB) : 1;
  logic [KW-1:0] k;
  assign last = beat_valid && k == KW'(NB - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      k <= '0;
      line <= '0;
    end else if (clr) begin
      k <= '0;
    end else if (beat_valid) begin
      line[k*DATA_W +: DATA_W] <= beat_data;
      k <= last ? '0 : k + 1'b1;
    end
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: sequences one line refill per fetch miss and writes it into the cache
module icache_refill_ctrl import icache_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  icache_refill_ctrl_if.master bus
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  refill_state_e state, state_d;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0] cnt;
  logic [LINE_W-1:0] line;
  logic kill, kill_d, hs, beat, last;
  assign hs = state == REQ && bus.mem_req_ready_i;
  assign beat = state == FILL && bus.mem_rsp_valid_i;
  icache_line_assembler #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .clr(hs),
    .beat_valid(beat),
    .beat_data(bus.mem_rsp_data_i),
    .line(line),
    .last(last)
  );
  always_comb begin
    state_d = state == IDLE  ? (bus.miss_i && !bus.flush_i ? REQ : IDLE) :
              state == REQ   ? (hs ? FILL : REQ) :
              state == FILL  ? (last ? WRITE : FILL) : IDLE;
    // a flush never aborts the transaction, it only silences the replay pulse
    kill_d = state == WRITE ? 1'b0 : kill | (state != IDLE && bus.flush_i);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      kill <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_d;
      kill <= kill_d;
      if (state == IDLE && state_d == REQ) addr <= ADDR_W'(line_align(64'(bus.miss_addr_i), OFF_W));
      if (state == WRITE) cnt <= cnt + 1'b1;
    end
  assign bus.mem_req_valid_o = state == REQ;
  assign bus.mem_req_addr_o = addr;
  assign bus.line_we_o = state == WRITE;
  assign bus.line_addr_o = addr;
  assign bus.line_data_o = line;
  assign bus.refill_done_o = state == WRITE && !kill && !bus.flush_i;
  assign bus.busy_o = state != IDLE;
  assign bus.refill_cnt_o = cnt;
endmodule
